seg7_scan_driver: RTL
=====================

Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed successor to the two-digit combinational 7-segment decoder.
- Drives DIGITS common-anode digits from one shared active-low segment bus with a rotating active-low anode select.
- Adds hex/decimal glyph mode, per-digit decimal point, blanking and blinking, leading-zero suppression, and tear-free frame-synchronous data update.
- Sits between application logic and the board LED pins.

Parameters:
- DIGITS, 4, number of multiplexed digits (2..8).
- SCAN_DIV, 1000, clocks per digit slot (>=2).
- BLINK_FRAMES, 64, full scan frames per blink half-period (>=1).
- HEX_EN, 1, 1: values A-F show glyphs; 0: values A-F show blank.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- val_in  in  4*DIGITS  digit values, nibble i = digit i (digit 0 = rightmost).
- dp_in  in  DIGITS  decimal point enable per digit (1 = lit).
- blank_in  in  DIGITS  force digit dark (1 = dark).
- blink_in  in  DIGITS  digit blinks (1 = blink).
- lzs_en  in  1  leading-zero suppression enable.
- load_in  in  1  single-cycle strobe; capture val_in/dp_in/blank_in/blink_in.
- seg_out  out  8  active-low segments, bit7 = dp, bits6..0 = g..a.
- an_out  out  DIGITS  active-low anode select, one-hot-low.
- frame_out  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (async assert, sync release):
  - seg_out = all ones; an_out = all ones; frame_out = 0.
  - Prescaler = 0; digit index = 0; blink frame counter = 0; blink phase = 0 (visible).
  - Shadow and active registers = 0; pending = 0.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. At terminal count, the index advances; at DIGITS-1 it wraps to 0.
- Frame boundary is the index wrap DIGITS-1 -> 0:
  - frame_out pulses in the same cycle the index becomes 0 (registered).
  - The blink frame counter advances; at BLINK_FRAMES-1 it wraps and toggles blink phase.
- Load and commit:
  - load_in = 1 captures all four inputs into shadow registers and sets pending.
  - At the frame boundary, if pending: active <= shadow, pending <= 0.
  - load_in coincident with the boundary: that cycle's inputs go straight to active and pending stays 0.
  - A second load before the boundary overwrites shadow; the last one wins.
  - The display only ever shows whole frames from a single load.
- Outputs: registered, 1 cycle after the index change.
  - Dead time: in the first cycle of every slot, an_out = all ones.
  - Otherwise an_out[index] = 0 and all other bits = 1.
- Glyphs (segments g..a, active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001.
  - 5 = 0010010, 6 = 0000010, 7 = 1011000, 8 = 0000000, 9 = 0010000.
  - A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110.
  - If HEX_EN = 0, values A-F give 1111111.
  - seg_out[7] = ~dp.
- Leading-zero suppression (lzs_en = 1):
  - Digits from DIGITS-1 downward with active value 0 are suppressed until the first nonzero digit.
  - Digit 0 is never suppressed.
  - A suppressed digit has glyph bits = 1111111 but still shows its dp.
  - A blanked digit does not end the zero run; its value is used.
- Dark priority:
  - blank, or (blink and phase = 1), forces the whole seg_out = 8'hFF, dp included.
  - Blanked digits are still scanned, so a dark digit's anode still asserts.
- lzs_en is a live input (not shadowed) and takes effect at the next slot.
- Reset mid-frame: outputs go dark immediately and all state clears; the pending load is lost.

Test Plan:
- Bench settings: DIGITS = 4, SCAN_DIV = 4, BLINK_FRAMES = 2.
- Reset, then release, no load -> an_out sequence 1111, 1110, 1110, 1110, 1111, 1101, ...; seg_out = 8'hC0 on every slot; frame_out pulses every 16 cycles.
- load val_in = 16'h12AF, HEX_EN = 1, mid-frame -> old data until the next frame_out, then digit0 = 8'h8E, digit1 = 8'h88, digit2 = 8'hA4, digit3 = 8'hF9.
- val_in = 16'h0040, lzs_en = 1, dp_in = 4'b1000 -> digit3 = 8'h7F, digit2 = 8'hFF, digit1 = 8'h99, digit0 = 8'hC0.
- blink_in = 4'b0001, val_in = 16'h0005 -> digit0 alternates 8'h92 (2 frames) and 8'hFF (2 frames); other digits show a steady 8'hC0.
- load_in in the same cycle as the boundary -> new values visible from slot 0 of the new frame. Two loads in one frame -> only the second is displayed.
- rst_n asserted mid-slot -> seg_out = 8'hFF and an_out = 4'hF in the same cycle; after release, the display shows 0s.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for DIGITS common-anode 7-segment
// digits on a shared active-low segment bus. It adds hex/decimal glyphs, a
// decimal point per digit, blanking, blinking and leading-zero suppression.
// New data is committed only at frame boundaries, so a frame never mixes loads.
module seg7_scan_driver #(
  parameter int DIGITS       = 4,    // multiplexed digits (2..8)
  parameter int SCAN_DIV     = 1000, // clocks per digit slot (>=2)
  parameter int BLINK_FRAMES = 64,   // frames per blink half-period (>=1)
  parameter int HEX_EN       = 1     // 1: A-F show glyphs, 0: A-F blank
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   val_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic [DIGITS-1:0]     blink_in,
  input  logic                  lzs_en,
  input  logic                  load_in,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     an_out,
  output logic                  frame_out
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(DIGITS);
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  // Scan timing state
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [BLK_W-1:0] blk_cnt;
  logic             blink_ph;   // 1 = blinking digits are dark

  // Shadow (loaded) and active (displayed) digit data
  logic [4*DIGITS-1:0] sh_val,   act_val;
  logic [DIGITS-1:0]   sh_dp,    act_dp;
  logic [DIGITS-1:0]   sh_blank, act_blank;
  logic [DIGITS-1:0]   sh_blink, act_blink;
  logic                pending;

  logic slot_end;
  logic frame_end;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // Glyph table, segments g..a, active-low. A-F blank when hex is disabled.
  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1011000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    if (HEX_EN == 0 && v > 4'd9) g = 7'b1111111;
    return g;
  endfunction

  // Prescaler, digit index, frame pulse and blink phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= '0;
      frame_out <= 1'b0;
      blk_cnt   <= '0;
      blink_ph  <= 1'b0;
    end else begin
      // NOTE: every sequential assignment is non-blocking so all registers
      // update from the same pre-edge values regardless of statement order.
      frame_out <= frame_end;
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (frame_end) begin
        if (blk_cnt == BLK_LAST) begin
          blk_cnt  <= '0;
          blink_ph <= ~blink_ph;
        end else begin
          blk_cnt <= blk_cnt + 1'b1;
        end
      end
    end
  end

  // Load capture into shadow and frame-synchronous commit into active
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data registers are reset too, so the first frame after
      // reset shows a defined all-zero display and no stale load survives.
      sh_val    <= '0;
      sh_dp     <= '0;
      sh_blank  <= '0;
      sh_blink  <= '0;
      act_val   <= '0;
      act_dp    <= '0;
      act_blank <= '0;
      act_blink <= '0;
      pending   <= 1'b0;
    end else if (frame_end) begin
      // A load on the boundary itself bypasses the shadow.
      if (load_in) begin
        act_val   <= val_in;
        act_dp    <= dp_in;
        act_blank <= blank_in;
        act_blink <= blink_in;
      end else if (pending) begin
        act_val   <= sh_val;
        act_dp    <= sh_dp;
        act_blank <= sh_blank;
        act_blink <= sh_blink;
      end
      pending <= 1'b0;
    end else if (load_in) begin
      sh_val   <= val_in;
      sh_dp    <= dp_in;
      sh_blank <= blank_in;
      sh_blink <= blink_in;
      pending  <= 1'b1;
    end
  end

  // Leading-zero run from the leftmost digit; blanked digits still count by value
  logic [DIGITS-1:0] supp;
  logic              zero_run;

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    supp     = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      supp[i]  = lzs_en && zero_run && (act_val[4*i +: 4] == 4'd0) && (i != 0);
      zero_run = zero_run && (act_val[4*i +: 4] == 4'd0);
    end
  end

  // Next segment and anode values for the digit currently being scanned
  logic [3:0]        cur_val;
  logic [6:0]        cur_glyph;
  logic [7:0]        seg_next;
  logic [DIGITS-1:0] an_next;

  always_comb begin
    cur_val   = act_val[4*idx +: 4];
    cur_glyph = supp[idx] ? 7'b1111111 : glyph(cur_val);
    seg_next  = {~act_dp[idx], cur_glyph};
    if (act_blank[idx] || (act_blink[idx] && blink_ph)) seg_next = 8'hFF;
    an_next = '1;
    // First cycle of each slot is dead time to avoid ghosting.
    if (cnt != '0) an_next[idx] = 1'b0;
  end

  // Registered outputs, dark during reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out <= 8'hFF;
      an_out  <= '1;
    end else begin
      seg_out <= seg_next;
      an_out  <= an_next;
    end
  end

endmodule
